// File: rtl/mem_wb_pkg.sv
// Shared definitions for the memory-access / writeback stage: bus widths,
// memory-op encodings, FSM states and the store-lane helpers.
package mem_wb_pkg;

    localparam int WORD_BUS     = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam logic [REG_ADDR_BUS-1:0] REG_ZERO = '0;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Undefined encodings (9..15) fall through every predicate and behave as NONE.
    function automatic logic is_load(input logic [3:0] op);
        return (op >= MEM_LB) && (op <= MEM_LW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= MEM_SB) && (op <= MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        if (op == MEM_LH || op == MEM_LHU || op == MEM_SH)
            bad = lane[0];
        else if (op == MEM_LW || op == MEM_SW)
            bad = (lane != 2'b00);
        return bad;
    endfunction

    // Byte enables; loads always fetch the whole word.
    function automatic logic [3:0] store_be(input logic [3:0] op, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b1111;
        if (op == MEM_SB)
            be = 4'b0001 << lane;
        else if (op == MEM_SH)
            be = lane[1] ? 4'b1100 : 4'b0011;
        return be;
    endfunction

    // Replicate the store source so the enabled lanes see the right bytes.
    function automatic logic [WORD_BUS-1:0] store_data(input logic [3:0] op,
                                                        input logic [WORD_BUS-1:0] sd);
        logic [WORD_BUS-1:0] wd;
        wd = '0;
        if (op == MEM_SB)
            wd = {4{sd[7:0]}};
        else if (op == MEM_SH)
            wd = {2{sd[15:0]}};
        else if (op == MEM_SW)
            wd = sd;
        return wd;
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Picks the addressed byte/halfword out of a read word and sign/zero extends it.
module load_align
    import mem_wb_pkg::*;
(
    input  logic [3:0]          mem_op,
    input  logic [1:0]          byte_sel,
    input  logic [WORD_BUS-1:0] rdata,
    output logic [WORD_BUS-1:0] result
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rdata[{byte_sel, 3'b000} +: 8];
    assign sel_half = byte_sel[1] ? rdata[31:16] : rdata[15:0];

    // Extension by load type; LW and anything else pass the word through.
    always_comb begin
        result = rdata;
        case (mem_op)
            MEM_LB:  result = {{24{sel_byte[7]}}, sel_byte};
            MEM_LBU: result = {24'd0, sel_byte};
            MEM_LH:  result = {{16{sel_half[15]}}, sel_half};
            MEM_LHU: result = {16'd0, sel_half};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: issues data-memory requests over a
// req/ack handshake, stalls upstream while busy, and drives the regfile port.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ex_valid,
    input  logic [REG_ADDR_BUS-1:0] ex_regDest,
    input  logic [WORD_BUS-1:0]     ex_result,
    input  logic [3:0]              ex_memOp,
    input  logic [WORD_BUS-1:0]     ex_storeData,
    output logic                    mem_stall,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDR_W-1:0]       dmem_addr,
    output logic [3:0]              dmem_be,
    output logic [WORD_BUS-1:0]     dmem_wdata,
    input  logic                    dmem_ack,
    input  logic [WORD_BUS-1:0]     dmem_rdata,
    output logic                    wb_writeEnable,
    output logic [REG_ADDR_BUS-1:0] wb_regDest,
    output logic [WORD_BUS-1:0]     wb_result,
    output logic                    exc_misaligned,
    output logic                    exc_busError
);

    state_e                  state_reg, state_next;
    logic [7:0]              cnt_reg, cnt_next;
    logic                    req_reg, req_next;
    logic                    we_reg, we_next;
    logic [ADDR_W-1:0]       addr_reg, addr_next;
    logic [3:0]              be_reg, be_next;
    logic [WORD_BUS-1:0]     wdata_reg, wdata_next;
    logic [3:0]              op_reg, op_next;
    logic [REG_ADDR_BUS-1:0] dest_reg, dest_next;
    logic [1:0]              lane_reg, lane_next;
    logic                    wb_we_reg, wb_we_next;
    logic [REG_ADDR_BUS-1:0] wb_dest_reg, wb_dest_next;
    logic [WORD_BUS-1:0]     wb_result_reg, wb_result_next;
    logic                    misal_reg, misal_next;
    logic                    buserr_reg, buserr_next;

    logic [ADDR_W-1:0]       ex_addr;
    logic [WORD_BUS-1:0]     load_data;

    assign ex_addr = ex_result[ADDR_W-1:0];

    load_align u_load_align (
        .mem_op   (op_reg),
        .byte_sel (lane_reg),
        .rdata    (dmem_rdata),
        .result   (load_data)
    );

    // Next-state, request and writeback decisions; ack wins over timeout.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        req_next       = req_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        be_next        = be_reg;
        wdata_next     = wdata_reg;
        op_next        = op_reg;
        dest_next      = dest_reg;
        lane_next      = lane_reg;
        wb_we_next     = 1'b0;
        wb_dest_next   = wb_dest_reg;
        wb_result_next = wb_result_reg;
        misal_next     = 1'b0;
        buserr_next    = 1'b0;
        mem_stall      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (is_load(ex_memOp) || is_store(ex_memOp)) begin
                        if (is_misaligned(ex_memOp, ex_result[1:0])) begin
                            misal_next = 1'b1;
                        end else begin
                            mem_stall  = 1'b1;
                            state_next = ST_BUSY;
                            cnt_next   = 8'd0;
                            req_next   = 1'b1;
                            we_next    = is_store(ex_memOp);
                            addr_next  = {ex_addr[ADDR_W-1:2], 2'b00};
                            be_next    = store_be(ex_memOp, ex_result[1:0]);
                            wdata_next = store_data(ex_memOp, ex_storeData);
                            op_next    = ex_memOp;
                            dest_next  = ex_regDest;
                            lane_next  = ex_result[1:0];
                        end
                    end else begin
                        wb_we_next     = (ex_regDest != REG_ZERO);
                        wb_dest_next   = ex_regDest;
                        wb_result_next = ex_result;
                    end
                end
            end
            ST_BUSY: begin
                if (dmem_ack) begin
                    state_next = ST_IDLE;
                    req_next   = 1'b0;
                    if (is_load(op_reg)) begin
                        wb_we_next     = (dest_reg != REG_ZERO);
                        wb_dest_next   = dest_reg;
                        wb_result_next = load_data;
                    end
                end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
                    state_next  = ST_IDLE;
                    req_next    = 1'b0;
                    buserr_next = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                    cnt_next  = cnt_reg + 8'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and output registers; active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            req_reg       <= 1'b0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            be_reg        <= '0;
            wdata_reg     <= '0;
            op_reg        <= '0;
            dest_reg      <= '0;
            lane_reg      <= '0;
            wb_we_reg     <= 1'b0;
            wb_dest_reg   <= '0;
            wb_result_reg <= '0;
            misal_reg     <= 1'b0;
            buserr_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_reg       <= req_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            be_reg        <= be_next;
            wdata_reg     <= wdata_next;
            op_reg        <= op_next;
            dest_reg      <= dest_next;
            lane_reg      <= lane_next;
            wb_we_reg     <= wb_we_next;
            wb_dest_reg   <= wb_dest_next;
            wb_result_reg <= wb_result_next;
            misal_reg     <= misal_next;
            buserr_reg    <= buserr_next;
        end
    end

    assign dmem_req       = req_reg;
    assign dmem_we        = we_reg;
    assign dmem_addr      = addr_reg;
    assign dmem_be        = be_reg;
    assign dmem_wdata     = wdata_reg;
    assign wb_writeEnable = wb_we_reg;
    assign wb_regDest     = wb_dest_reg;
    assign wb_result      = wb_result_reg;
    assign exc_misaligned = misal_reg;
    assign exc_busError   = buserr_reg;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_regDest;
    logic [31:0] ex_result;
    logic [3:0]  ex_memOp;
    logic [31:0] ex_storeData;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        wb_writeEnable;
    logic [4:0]  wb_regDest;
    logic [31:0] wb_result;
    logic        exc_misaligned;
    logic        exc_busError;

    int n_checks = 0;
    int n_pass   = 0;

    mem_wb_stage #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_regDest     (ex_regDest),
        .ex_result      (ex_result),
        .ex_memOp       (ex_memOp),
        .ex_storeData   (ex_storeData),
        .mem_stall      (mem_stall),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .wb_writeEnable (wb_writeEnable),
        .wb_regDest     (wb_regDest),
        .wb_result      (wb_result),
        .exc_misaligned (exc_misaligned),
        .exc_busError   (exc_busError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] dest,
                         input logic [31:0] res, input logic [31:0] sd);
        ex_valid     = v;
        ex_memOp     = op;
        ex_regDest   = dest;
        ex_result    = res;
        ex_storeData = sd;
        #1;
    endtask

    initial begin
        rst = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        step(); step();
        $display("txn reset");
        chk("rst_wb_we",  {31'd0, wb_writeEnable}, 32'd0);
        chk("rst_req",    {31'd0, dmem_req}, 32'd0);
        chk("rst_stall",  {31'd0, mem_stall}, 32'd0);
        chk("rst_result", wb_result, 32'd0);
        chk("rst_exc",    {30'd0, exc_misaligned, exc_busError}, 32'd0);
        rst = 1'b1;

        // ALU op
        $display("txn alu dest=5 result=0x1234");
        drive(1'b1, 4'd0, 5'd5, 32'h1234, 32'd0);
        chk("alu_stall", {31'd0, mem_stall}, 32'd0);
        step();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        chk("alu_we",     {31'd0, wb_writeEnable}, 32'd1);
        chk("alu_dest",   {27'd0, wb_regDest}, 32'd5);
        chk("alu_result", wb_result, 32'h1234);
        step();
        chk("idle_we",    {31'd0, wb_writeEnable}, 32'd0);
        chk("idle_hold",  wb_result, 32'h1234);

        // LB signed, ack on 4th stall cycle (coincides with last timeout cycle)
        $display("txn lb addr=0x103 ack after 3 wait cycles");
        drive(1'b1, 4'd1, 5'd7, 32'h103, 32'd0);
        chk("lb_stall0", {31'd0, mem_stall}, 32'd1);
        step();
        chk("lb_req",   {31'd0, dmem_req}, 32'd1);
        chk("lb_we",    {31'd0, dmem_we}, 32'd0);
        chk("lb_be",    {28'd0, dmem_be}, 32'hF);
        chk("lb_addr",  dmem_addr, 32'h100);
        chk("lb_wbwe",  {31'd0, wb_writeEnable}, 32'd0);
        chk("lb_stall1", {31'd0, mem_stall}, 32'd1);
        step();
        chk("lb_stall2", {31'd0, mem_stall}, 32'd1);
        step();
        chk("lb_stall3", {31'd0, mem_stall}, 32'd1);
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        chk("lb_stall_ack", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("lb_wbwe_done", {31'd0, wb_writeEnable}, 32'd1);
        chk("lb_dest",      {27'd0, wb_regDest}, 32'd7);
        chk("lb_result",    wb_result, 32'hFFFF_FF80);
        chk("lb_req_done",  {31'd0, dmem_req}, 32'd0);
        chk("lb_buserr",    {31'd0, exc_busError}, 32'd0);

        // SH to upper half
        $display("txn sh addr=0x202 data=0xAAAABEEF");
        drive(1'b1, 4'd7, 5'd0, 32'h202, 32'hAAAA_BEEF);
        chk("sh_stall0", {31'd0, mem_stall}, 32'd1);
        step();
        chk("sh_we",    {31'd0, dmem_we}, 32'd1);
        chk("sh_be",    {28'd0, dmem_be}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr",  dmem_addr, 32'h200);
        dmem_ack = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        chk("sh_stall_ack", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("sh_wbwe", {31'd0, wb_writeEnable}, 32'd0);
        chk("sh_req",  {31'd0, dmem_req}, 32'd0);

        // SB to byte 1
        $display("txn sb addr=0x001 data=0x123456A5");
        drive(1'b1, 4'd6, 5'd0, 32'h001, 32'h1234_56A5);
        step();
        chk("sb_be",    {28'd0, dmem_be}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        dmem_ack = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        step();
        dmem_ack = 1'b0;

        // LH and LHU on upper half
        $display("txn lh addr=0x102 rdata=0x80010000");
        drive(1'b1, 4'd3, 5'd8, 32'h102, 32'd0);
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("lh_result", wb_result, 32'hFFFF_8001);
        $display("txn lhu addr=0x102 rdata=0x80010000");
        drive(1'b1, 4'd4, 5'd8, 32'h102, 32'd0);
        step();
        dmem_ack = 1'b1;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("lhu_result", wb_result, 32'h0000_8001);

        // LW misaligned
        $display("txn lw misaligned addr=0x101");
        drive(1'b1, 4'd5, 5'd3, 32'h101, 32'd0);
        chk("mis_stall", {31'd0, mem_stall}, 32'd0);
        step();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        chk("mis_exc",  {31'd0, exc_misaligned}, 32'd1);
        chk("mis_req",  {31'd0, dmem_req}, 32'd0);
        chk("mis_wbwe", {31'd0, wb_writeEnable}, 32'd0);
        step();
        chk("mis_pulse", {31'd0, exc_misaligned}, 32'd0);

        // Timeout with TIMEOUT=4
        $display("txn lw addr=0x300 no ack (timeout)");
        drive(1'b1, 4'd5, 5'd4, 32'h300, 32'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req%0d", i), {31'd0, dmem_req}, 32'd1);
            chk($sformatf("to_stall%0d", i), {31'd0, mem_stall}, (i < 3) ? 32'd1 : 32'd0);
            if (i == 3) drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
            step();
        end
        chk("to_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("to_buserr",   {31'd0, exc_busError}, 32'd1);
        chk("to_wbwe",     {31'd0, wb_writeEnable}, 32'd0);
        $display("txn alu after timeout dest=9 result=0xCAFE");
        drive(1'b1, 4'd0, 5'd9, 32'hCAFE, 32'd0);
        step();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        chk("to_pulse",   {31'd0, exc_busError}, 32'd0);
        chk("post_we",    {31'd0, wb_writeEnable}, 32'd1);
        chk("post_result", wb_result, 32'hCAFE);

        // Undefined memOp behaves as NONE
        $display("txn op=9 treated as alu dest=2 result=0x55");
        drive(1'b1, 4'd9, 5'd2, 32'h55, 32'd0);
        chk("op9_stall", {31'd0, mem_stall}, 32'd0);
        step();
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        chk("op9_result", wb_result, 32'h55);

        // Reset during BUSY, stale ack afterwards
        $display("txn reset mid-access then stale ack");
        drive(1'b1, 4'd5, 5'd6, 32'h400, 32'd0);
        step();
        chk("rb_req", {31'd0, dmem_req}, 32'd1);
        rst = 1'b0;
        drive(1'b0, 4'd0, 5'd0, 32'd0, 32'd0);
        step();
        chk("rb_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("rb_result",   wb_result, 32'd0);
        chk("rb_dest",     {27'd0, wb_regDest}, 32'd0);
        rst = 1'b1;
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'h1234_5678;
        #1;
        chk("rb_stale_stall", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("rb_stale_we",     {31'd0, wb_writeEnable}, 32'd0);
        chk("rb_stale_result", wb_result, 32'd0);
        chk("rb_stale_req",    {31'd0, dmem_req}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. Sits between the EX/MEM register and the register file.
- Performs loads and stores to data memory over a req/ack handshake and stalls the upstream pipeline while an access is outstanding.
- Drives the register file write port (wb_writeEnable, wb_regDest, wb_result) from registered outputs.

Parameters:
- ADDR_W, 32, data-memory address width
- TIMEOUT, 16, max cycles to wait for dmem_ack before a bus error (range 2..255)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset (reset when rst==0 at posedge)
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_regDest  in  5  destination register (0 = no write)
- ex_result  in  32  ALU result, or effective address for memory ops
- ex_memOp  in  4  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; others treated as NONE
- ex_storeData  in  32  store source register value
- mem_stall  out  1  freeze EX/MEM and earlier stages
- dmem_req  out  1  access request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits forced 0)
- dmem_be  out  4  byte enables, little-endian (bit0 = addr byte 0)
- dmem_wdata  out  32  store data, replicated into lanes
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  read data, valid with ack
- wb_writeEnable  out  1  register file write strobe
- wb_regDest  out  5  register file write address
- wb_result  out  32  register file write data
- exc_misaligned  out  1  one-cycle pulse on a misaligned access
- exc_busError  out  1  one-cycle pulse on a timeout

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, timeout counter = 0.
- FSM states: IDLE and BUSY.
- Non-memory instruction in IDLE (ex_valid, memOp NONE):
  - At the next edge, wb_writeEnable = (ex_regDest != 0), wb_regDest/wb_result are loaded from ex_regDest/ex_result.
  - Latency 1, mem_stall = 0.
- ex_valid == 0 in IDLE: at the next edge wb_writeEnable = 0; wb_regDest/wb_result hold.
- Aligned memory op in IDLE:
  - mem_stall = 1 combinationally in the same cycle.
  - Next edge: go to BUSY, latch op/dest/address, assert dmem_req.
  - dmem_we/dmem_be/dmem_wdata/dmem_addr are registered and stable while dmem_req is high. Timeout counter cleared.
  - wb_writeEnable = 0 while in BUSY.
- BUSY:
  - mem_stall = ~dmem_ack. The counter increments each cycle without ack.
  - On ack (edge): dmem_req = 0, return to IDLE.
  - Loads: wb_writeEnable = (dest != 0), wb_result = extracted data.
  - Stores: wb_writeEnable = 0.
  - The upstream instruction advances in the ack cycle, so the next op may be accepted on the following edge. No back-to-back request without one IDLE cycle.
- Timeout: counter reaches TIMEOUT-1 without ack → next edge drops req, returns to IDLE, pulses exc_busError, wb_writeEnable = 0. mem_stall falls in that last cycle.
- Load extraction (byte = addr[1:0], half = addr[1]):
  - LB sign-extends the selected byte; LBU zero-extends it.
  - LH sign-extends the selected halfword; LHU zero-extends it.
  - LW passes the full word.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{byte}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{half}}.
  - SW: be = 4'b1111.
  - Loads drive be = 4'b1111.
- Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0):
  - No request is issued, mem_stall = 0.
  - Next edge: exc_misaligned = 1 for one cycle, wb_writeEnable = 0.
- A dmem_ack arriving while in IDLE is ignored.
- Reset mid-access: dmem_req drops at that edge, FSM returns to IDLE, and any later stale ack is ignored.
- Reset overrides everything; no partial writeback is performed.

Decomposition:
- Shared package/header: memOp encodings, WORD_BUS/REG_ADDR_BUS widths, REG_ZERO.
- One sub-module, load_align: purely combinational (memOp, addr[1:0], rdata) → 32-bit extended result. It is reused later by any cache fill path.
- FSM, counter and store-lane logic stay in the top module.

Test Plan:
- ALU op: ex_valid=1, memOp=NONE, regDest=5, result=0x1234 → next cycle wb_writeEnable=1, wb_regDest=5, wb_result=0x1234; mem_stall never 1.
- LB with sign: addr=0x103, ack after 3 cycles with rdata=0x80FF_0000 → mem_stall high 4 cycles, dmem_be=4'b1111, then wb_result=0xFFFF_FF80.
- SH at addr=0x202, storeData=0xAAAA_BEEF → dmem_we=1, be=4'b1100, wdata=0xBEEF_BEEF, addr=0x200; after ack, wb_writeEnable=0.
- LW at addr=0x101 → no dmem_req, exc_misaligned pulse next cycle, wb_writeEnable=0, mem_stall=0.
- TIMEOUT=4 with no ack → dmem_req high 4 cycles, then exc_busError pulse, FSM back to IDLE, next ALU op completes normally.
- rst=0 asserted while in BUSY, late ack after release → all outputs 0, no writeback, ack ignored.
